eq_i2s_tx: RTL
==============

# eq_i2s_tx

Output serializer of the equalizer: consumes the 24-bit mixed sample produced by the band-weighting/summing stage and transmits it as standard Philips I2S, 64 bit-clocks per frame. The mono sample is sent on both the left and right slots. A one-entry holding register with a valid/ready handshake decouples the mixer from the frame rate. Underruns are flagged and counted.

## Interface
- CLK_DIV, 4, clk cycles per half bclk period (≥2); bclk period = 2·CLK_DIV clk, frame = 128·CLK_DIV clk
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  serializer enable
- sample_in  in  24  signed two's-complement sample from the mixer
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  holding register empty (= ~hold_full; 0 while rst_n=0)
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select: 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty
- underrun_cnt  out  8  saturating underrun count

## Operation
- Handshake: sample is accepted when sample_valid && sample_ready at a clk edge. It is written to the holding register and hold_full is set. sample_in must be held while valid && !ready.
- Divider: div counts 0..CLK_DIV-1 while en=1. At div==CLK_DIV-1, bclk toggles on the next edge and div wraps to 0. A toggle with bclk=1 is a falling event.
- Bit counter bit_cnt[5:0] increments on each falling event and wraps 63→0. lrclk = bit_cnt[5]. All lrclk and sdata changes coincide with bclk falling.
- Slot position p = bit_cnt[4:0]:
  - p=0: sdata=0 (I2S one-bit delay)
  - p=1..24: sdata = frame_reg[24-p]
  - p=25..31: sdata=0
- Left MSB is at bit_cnt=1; right MSB is at bit_cnt=33.
- Frame load, on the falling event that wraps bit_cnt 63→0:
  - hold_full=1: frame_reg ← holding, hold_full cleared.
  - hold_full=0: frame_reg ← 0, underrun pulses for 1 clk, underrun_cnt increments and saturates at 255.
- Simultaneous accept and load: ready is evaluated before the load. A sample accepted in the load cycle of an empty buffer still raises underrun for this frame, and the sample is sent in the next frame.
- First frame after reset or after en rises: frame_reg=0, all zeros are transmitted, and no underrun is flagged.
- en=0 (synchronous):
  - div, bit_cnt, bclk, lrclk, sdata and frame_reg are forced to 0.
  - The holding register and handshake keep working.
  - No underrun is flagged.
  - When en returns to 1, transmission restarts exactly as after reset.

## Timing
- Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, underrun_cnt=0, sample_ready=0.
- Internal reset state: hold_full=0, div=0, bit_cnt=0, frame_reg=0.
- sample_ready=1 from the first clk after rst_n rises.
- Handshake latency: accept at edge k gives sample_ready=0 at k+1. Ready returns high in the clk after the frame-load edge.
- Output latency: an accepted sample reaches sdata at the next frame boundary (worst case 128·CLK_DIV clk), MSB first, one bclk after lrclk falls.
- bclk: 50% duty, first rising edge CLK_DIV clk after en/reset release.
- Reset mid-frame: all outputs return to reset values at the next edge. The held sample is discarded and underrun_cnt is cleared.
- All outputs are registered except sample_ready.

## Test plan
- Reset/idle: rst_n=0 for 4 clk, then en=1 with no samples, CLK_DIV=4.
  - During reset: all outputs 0.
  - bclk period 8 clk; lrclk toggles every 256 clk.
  - sdata=0 throughout.
  - underrun pulses at each frame boundary after the first; underrun_cnt=1,2,3.
- Serial format: send 0xA5A5A5, then 0x800001.
  - Frame 2 left and right slots each carry bits 101001011010010110100101 at bit_cnt 1..24 / 33..56; zeros elsewhere.
  - Frame 3 carries 100000000000000000000001.
  - Sample on bclk rising edges.
- Back-pressure: keep sample_valid=1 with incrementing data 1,2,3,…
  - Exactly one sample is accepted per frame.
  - sample_ready is low between accept and load.
  - No sample is skipped or duplicated; no underrun after the first load.
- Boundary accept: assert the first sample exactly in the frame-load cycle of an empty buffer.
  - underrun pulses once for that frame.
  - The sample appears in the following frame.
- Underrun saturation: run 300 frames with no input → underrun_cnt stops at 255.
- Reset/enable mid-frame:
  - rst_n=0 at bit_cnt=10 of a frame carrying 0x7FFFFF → outputs 0 next clk; the held sample is lost.
  - Separately, en=0 for 50 clk mid-frame → outputs 0; the held sample survives and is transmitted in the second frame after en rises.

Source files
------------

// File: rtl/eq_i2s_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : eq_i2s_tx_if
//  Description : Sample handshake between the equalizer mixer (master) and
//                the I2S output serializer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface eq_i2s_tx_if;
    logic [23:0] sample_in;     // signed two's-complement mixed sample
    logic        sample_valid;  // sample_in valid
    logic        sample_ready;  // serializer holding register empty

    // The mixer produces samples and observes back-pressure.
    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    // The serializer consumes samples and drives back-pressure.
    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/eq_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : eq_i2s_tx
//  Description : Equalizer output serializer. Takes the mono 24-bit mixed
//                sample through a one-entry holding register and sends it on
//                both slots of a Philips I2S frame (64 bclk per frame, MSB
//                first, one-bit delay after lrclk). Empty frames are flagged
//                as underruns and counted with saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module eq_i2s_tx #(
    parameter int CLK_DIV = 4           // clk cycles per half bclk period (>= 2)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,      // synchronous, active-low
    input  wire logic       en,         // serializer enable
    eq_i2s_tx_if.slave      smp,        // sample handshake from the mixer
    output logic            i2s_bclk,
    output logic            i2s_lrclk,
    output logic            i2s_sdata,
    output logic            underrun,
    output logic [7:0]      underrun_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [5:0]         c_BIT_LAST = 6'd63;
    localparam logic [7:0]         c_CNT_MAX  = 8'd255;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;          // clk counter within a bclk half period
    logic               r_bclk;
    logic [5:0]         r_bit_cnt;      // bclk position within the frame
    logic               r_lrclk;
    logic               r_sdata;
    logic [23:0]        r_frame;        // sample being transmitted this frame
    logic [23:0]        r_hold;         // one-entry holding register
    logic               r_hold_full;
    logic               r_underrun;
    logic [7:0]         r_underrun_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_tick;         // bclk toggles at this edge
    logic               w_fall;         // bclk goes 1 -> 0 at this edge
    logic               w_load;         // frame boundary: bit_cnt wraps 63 -> 0
    logic               w_accept;       // handshake completes at this edge
    logic [5:0]         w_bit_next;
    logic [4:0]         w_pos_next;     // slot position after this falling event
    logic [31:0]        w_slot;         // slot image indexed by 31 - position
    logic               w_sdata_next;

    assign w_tick     = en && (r_div == c_DIV_LAST);
    assign w_fall     = w_tick && r_bclk;
    assign w_load     = w_fall && (r_bit_cnt == c_BIT_LAST);
    assign w_accept   = smp.sample_valid && smp.sample_ready;
    assign w_bit_next = r_bit_cnt + 6'd1;
    assign w_pos_next = w_bit_next[4:0];

    // One slot laid out so that position p selects bit 31-p: position 0 is the
    // I2S delay bit, 1..24 carry the sample MSB first, 25..31 are padding.
    // A load only happens when the next position is 0, which is always a zero
    // here, so the old frame_reg can be used without a bypass from the hold.
    assign w_slot       = {1'b0, r_frame, 7'b0};
    assign w_sdata_next = w_slot[5'd31 - w_pos_next];

    // Ready is the empty flag, held low while reset is asserted.
    assign smp.sample_ready = rst_n && !r_hold_full;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Divide clk down to bclk; disabled serializer parks with bclk low.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + c_DIV_ONE;
        end
    end

    // Advance the bit position and launch lrclk/sdata on each bclk falling event.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_bit_cnt <= '0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lrclk   <= w_bit_next[5];
            r_sdata   <= w_sdata_next;
        end
    end

    // Load the next frame from the holding register, or silence if it is empty.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_frame <= '0;
        end else if (w_load) begin
            r_frame <= r_hold_full ? r_hold : 24'd0;
        end
    end

    // Capture an accepted sample; the data path keeps working while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= smp.sample_in;
        end
    end

    // Full flag: an accept can only happen when empty, so it wins over a load
    // in the same cycle (that load already saw the buffer as empty).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Flag a frame that starts with nothing to send and count it (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= w_load && !r_hold_full;
            if (w_load && !r_hold_full && (r_underrun_cnt != c_CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_sdata    = r_sdata;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire
